// File: rtl/parking_gate_arbiter.sv
// Single barrier shared by entry and exit lanes: round-robin arbitration,
// open/close sequencing with pass timeout, and lot occupancy tracking.
module parking_gate_arbiter #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int OPEN_TIMEOUT = 16,
  parameter int CLOSE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_pass,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic             entry_done,
  output logic             exit_done,
  output logic             timeout,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  localparam logic [7:0] OPEN_LAST  = 8'(OPEN_TIMEOUT - 1);
  localparam logic [7:0] CLOSE_LAST = 8'(CLOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [7:0]       timer, timer_n;
  logic [CNT_W-1:0] occ_n;
  logic             gate_n, ge_n, gx_n;
  logic             ed_n, xd_n, to_n;
  logic             last_exit, last_exit_n;
  logic             entry_ok, exit_ok, pick_entry;

  assign full  = (occupancy == CAP);
  assign empty = (occupancy == '0);

  assign entry_ok   = entry_req && !full;
  assign exit_ok    = exit_req && !empty;
  // Tie goes to the lane that was not served last.
  assign pick_entry = entry_ok && (!exit_ok || last_exit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      occupancy   <= '0;
      gate_open   <= 1'b0;
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
      entry_done  <= 1'b0;
      exit_done   <= 1'b0;
      timeout     <= 1'b0;
      last_exit   <= 1'b1;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      occupancy   <= occ_n;
      gate_open   <= gate_n;
      grant_entry <= ge_n;
      grant_exit  <= gx_n;
      entry_done  <= ed_n;
      exit_done   <= xd_n;
      timeout     <= to_n;
      last_exit   <= last_exit_n;
    end
  end

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    occ_n       = occupancy;
    gate_n      = gate_open;
    ge_n        = grant_entry;
    gx_n        = grant_exit;
    ed_n        = 1'b0;
    xd_n        = 1'b0;
    to_n        = 1'b0;
    last_exit_n = last_exit;
    unique case (state)
      IDLE: begin
        if (entry_ok || exit_ok) begin
          state_n     = OPEN;
          timer_n     = '0;
          gate_n      = 1'b1;
          ge_n        = pick_entry;
          gx_n        = !pick_entry;
          last_exit_n = !pick_entry;
        end
      end
      OPEN: begin
        if (car_pass || timer == OPEN_LAST) begin
          state_n = CLOSE;
          timer_n = '0;
          gate_n  = 1'b0;
          ge_n    = 1'b0;
          gx_n    = 1'b0;
          if (!car_pass) begin
            to_n = 1'b1;
          end else if (grant_entry) begin
            occ_n = occupancy + ONE;
            ed_n  = 1'b1;
          end else begin
            occ_n = occupancy - ONE;
            xd_n  = 1'b1;
          end
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      CLOSE: begin
        if (timer == CLOSE_LAST) begin
          state_n = IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Randomised and directed bench for parking_gate_arbiter, checked every
// cycle against a lane-ownership model with open/close countdowns.
module tb_parking_gate_arbiter;

  localparam int CAP  = 3;
  localparam int CW   = 4;
  localparam int OT   = 4;
  localparam int CC   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          entry_req = 1'b0;
  logic          exit_req = 1'b0;
  logic          car_pass = 1'b0;
  logic          gate_open, grant_entry, grant_exit;
  logic          entry_done, exit_done, timeout;
  logic [CW-1:0] occupancy;
  logic          full, empty;

  int checks = 0;
  int failures = 0;

  // model: owner 0=none 1=entry 2=exit
  int m_owner, m_open_cyc, m_close_left, m_occ, m_last;
  bit m_ed, m_xd, m_to;

  parking_gate_arbiter #(
    .CAPACITY(CAP), .CNT_W(CW),
    .OPEN_TIMEOUT(OT), .CLOSE_CYCLES(CC)
  ) dut (
    .clk(clk), .rst(rst),
    .entry_req(entry_req), .exit_req(exit_req),
    .car_pass(car_pass),
    .gate_open(gate_open),
    .grant_entry(grant_entry), .grant_exit(grant_exit),
    .entry_done(entry_done), .exit_done(exit_done),
    .timeout(timeout), .occupancy(occupancy),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_open_cyc = 0; m_close_left = 0;
    m_occ = 0; m_last = 2;
    m_ed = 0; m_xd = 0; m_to = 0;
  endtask

  task automatic model_edge(input bit e, input bit x, input bit p);
    bit eo, xo;
    m_ed = 0; m_xd = 0; m_to = 0;
    if (m_owner != 0) begin
      m_open_cyc++;
      if (p) begin
        if (m_owner == 1) begin m_occ++; m_ed = 1; end
        else begin m_occ--; m_xd = 1; end
        m_owner = 0; m_close_left = CC;
      end else if (m_open_cyc == OT) begin
        m_to = 1;
        m_owner = 0; m_close_left = CC;
      end
    end else if (m_close_left > 0) begin
      m_close_left--;
    end else begin
      eo = e && (m_occ < CAP);
      xo = x && (m_occ > 0);
      if (eo && xo) m_owner = (m_last == 2) ? 1 : 2;
      else if (eo) m_owner = 1;
      else if (xo) m_owner = 2;
      if (m_owner != 0) begin
        m_last = m_owner;
        m_open_cyc = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("gate_open", gate_open, m_owner != 0);
    chk("grant_entry", grant_entry, m_owner == 1);
    chk("grant_exit", grant_exit, m_owner == 2);
    chk("entry_done", entry_done, m_ed);
    chk("exit_done", exit_done, m_xd);
    chk("timeout", timeout, m_to);
    chk("occupancy", occupancy, m_occ);
    chk("full", full, m_occ == CAP);
    chk("empty", empty, m_occ == 0);
  endtask

  task automatic step(input bit e, input bit x, input bit p);
    @(negedge clk);
    entry_req = e; exit_req = x; car_pass = p;
    @(posedge clk);
    model_edge(e, x, p);
    #1;
    compare_all();
  endtask

  // Hold requests until a grant, then pulse car_pass once.
  task automatic serve(input bit e, input bit x);
    int n;
    n = 0;
    while (m_owner == 0 && n < 40) begin
      step(e, x, 0);
      n++;
    end
    chk("serve_grant_bound", n < 40, 1);
    step(e, x, 1);
  endtask

  initial begin
    int gcnt;
    bit e, x;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_gate", gate_open, 0);

    // single entry
    step(1, 0, 0);
    chk("lit_gate_after_req", gate_open, 1);
    chk("lit_grant_entry", grant_entry, 1);
    step(1, 0, 1);
    chk("lit_entry_done", entry_done, 1);
    chk("lit_occ1", occupancy, 1);
    chk("lit_gate_closed", gate_open, 0);
    step(0, 0, 0);
    chk("lit_done_one_cycle", entry_done, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    // fill to capacity, then a blocked entry
    serve(1, 0);
    serve(1, 0);
    repeat (CC + 1) step(0, 0, 0);
    chk("lit_occ3", occupancy, 3);
    chk("lit_full", full, 1);
    gcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      gcnt += gate_open;
    end
    chk("lit_full_no_grant", gcnt, 0);

    // exit frees a slot; pending entry follows
    serve(1, 1);
    chk("lit_exit_done", exit_done, 1);
    chk("lit_occ2", occupancy, 2);
    chk("lit_not_full", full, 0);
    serve(1, 0);
    chk("lit_pending_entry", occupancy, 3);

    // round-robin: last served entry, so exit, entry, exit, entry
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      while (m_owner == 0 && n < 40) begin
        step(1, 1, 0);
        n++;
      end
      chk("lit_rr_grant_exit", grant_exit, (i % 2 == 0) ? 1 : 0);
      step(1, 1, 1);
    end

    // timeout on exit lane
    begin
      int n, open_cyc;
      n = 0;
      open_cyc = 0;
      while (gate_open == 0 && n < 40) begin
        step(0, 1, 0);
        n++;
      end
      while (gate_open == 1 && open_cyc < 40) begin
        open_cyc++;
        step(0, 1, 0);
      end
      chk("lit_open_cycles", open_cyc, OT);
      chk("lit_timeout_pulse", timeout, 1);
      chk("lit_timeout_occ", occupancy, 3);
    end
    repeat (CC + 2) step(0, 0, 1);

    // random traffic
    e = 0; x = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) e = ~e;
      if ($urandom_range(0, 9) == 0) x = ~x;
      step(e, x, $urandom_range(0, 3) == 0);
    end

    // async reset during OPEN
    begin
      int n;
      n = 0;
      while (m_owner == 0 && n < 60) begin
        step(1, 1, 0);
        n++;
      end
      chk("rst_mid_open_reached", gate_open, 1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("lit_async_gate", gate_open, 0);
      chk("lit_async_grants", grant_entry | grant_exit, 0);
      chk("lit_async_occ", occupancy, 0);
      chk("lit_async_empty", empty, 1);
      @(negedge clk);
      rst = 1'b0;
      entry_req = 0; exit_req = 0; car_pass = 0;
      step(0, 1, 0);
      step(1, 0, 0);
      step(1, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shares a single parking barrier between an entry lane and an exit lane. It arbitrates lane requests, sequences the gate through open, pass and close phases with a pass timeout, and maintains lot occupancy against a parameterised capacity. It sits between the lane sensors/request logic and the barrier actuator, and replaces ad-hoc per-lane gate control in the parking subsystem.

## Interface
- CAPACITY, 8: maximum cars in lot; must satisfy 1 ≤ CAPACITY < 2^CNT_W.
- CNT_W, 4: occupancy counter width.
- OPEN_TIMEOUT, 16: max cycles gate stays open awaiting car_pass; range 1..255.
- CLOSE_CYCLES, 4: gate-closing settle time in cycles; range 1..255.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- entry_req  in  1  entry lane request, level, held until entry_done or timeout.
- exit_req  in  1  exit lane request, level, held until exit_done or timeout.
- car_pass  in  1  single-cycle pulse from barrier loop sensor: car cleared gate.
- gate_open  out  1  barrier open command (registered).
- grant_entry  out  1  gate currently owned by entry lane (registered).
- grant_exit  out  1  gate currently owned by exit lane (registered).
- entry_done  out  1  one-cycle pulse: entry car passed, count incremented.
- exit_done  out  1  one-cycle pulse: exit car passed, count decremented.
- timeout  out  1  one-cycle pulse: open phase expired with no car_pass.
- occupancy  out  CNT_W  current car count (registered).
- full  out  1  occupancy == CAPACITY (decoded from registered count).
- empty  out  1  occupancy == 0 (decoded from registered count).

## Operation
- States: IDLE, OPEN, CLOSE. Reset: IDLE, occupancy=0, gate_open=0, grants=0, pulses=0, full=0, empty=1, last_served=EXIT, timer=0.
- Eligibility in IDLE: entry eligible = entry_req && !full; exit eligible = exit_req && !empty.
- Arbitration: only one eligible -> grant it; both eligible -> grant lane opposite last_served (round-robin). last_served is updated on grant. Reset value EXIT, so entry wins the first contest.
- IDLE -> OPEN on grant: gate_open=1, matching grant_* = 1, timer cleared.
- OPEN, car_pass=1: entry grant -> occupancy+1, entry_done pulse. Exit grant -> occupancy-1, exit_done pulse. gate_open=0, grants=0, go to CLOSE.
- OPEN, timer == OPEN_TIMEOUT-1 and no car_pass: timeout pulse, occupancy unchanged, gate_open=0, grants=0, go to CLOSE. car_pass on that same cycle takes priority and counts as a pass, not a timeout.
- CLOSE: wait CLOSE_CYCLES cycles with gate_open=0, then IDLE. No grants are made during CLOSE.
- car_pass outside OPEN: ignored.
- Requests while full (entry) or empty (exit) stay pending and are not granted. Exit is unaffected by full.
- Occupancy never wraps. Eligibility gating guarantees no increment at CAPACITY and no decrement at 0.
- Request dropped during OPEN: gate phase continues to pass/timeout. Requester must hold its request; arbiter does not re-check.

## Timing
- Request high at edge N while IDLE -> gate_open and grant high after edge N (1-cycle latency).
- car_pass sampled at edge M in OPEN -> occupancy, done pulse, gate_open=0 all effective after edge M. Pulse lasts exactly one cycle.
- Timeout: gate_open high for exactly OPEN_TIMEOUT cycles, then timeout pulse coincides with first gate_open=0 cycle.
- CLOSE occupies CLOSE_CYCLES cycles. Next grant can appear at earliest 1 cycle after CLOSE ends.
- Minimum back-to-back service period: 1 + 1 (pass at first OPEN cycle) + CLOSE_CYCLES cycles.
- rst asserted at any time, including mid-OPEN, forces all outputs to reset values immediately (asynchronously). Occupancy is lost.

## Test plan
- Reset/single entry (CAPACITY=3, OPEN_TIMEOUT=4, CLOSE_CYCLES=2): entry_req at cycle 1, car_pass at cycle 3 -> gate_open/grant_entry high cycles 2-3, entry_done pulse and occupancy=1 after cycle 3, empty=0, gate_open low ≥2 cycles.
- Fill to capacity: 3 entry passes -> occupancy=3, full=1. Fourth entry_req held 20 cycles -> no grant, gate_open stays 0. Then exit_req + car_pass -> exit_done, occupancy=2, full=0, pending entry granted after CLOSE.
- Round-robin: entry_req and exit_req both held continuously with occupancy=1, pass each time -> grants alternate entry, exit, entry, exit. Occupancy alternates 2,1,2,1.
- Timeout: entry_req, no car_pass -> gate_open high exactly 4 cycles, timeout pulse, occupancy unchanged, gate closed for 2 cycles, request re-granted.
- Empty lot exit: exit_req with occupancy=0 -> never granted. Stray car_pass in IDLE/CLOSE -> occupancy unchanged, no done pulse.
- Reset mid-operation: assert rst during OPEN with occupancy=2 -> gate_open=0, grants=0, occupancy=0, empty=1 without waiting for a clock edge.
